phase_cal_seq: RTL and testbench

Runtime phase-calibration sequencer for the Ising machine optical path. On a CPU trigger it biases the a/b/c intensity modulators to their calibration levels, then sweeps the phi_lo modulator against the MAC ADC stream and the phi modulator against the NL ADC stream. At each step it scores the absolute error to the expected value and latches the lowest-error phase word. The experiment FSM's phase outputs are driven from this block while it is busy or once a calibration result is in use.

---
 rtl/ising_config.sv | 30 +++
 rtl/abs_err_acc.sv | 37 +++
 rtl/phase_cal_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_phase_cal_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_config.sv
// Purpose: shared Ising-machine configuration: data width, phase-cal FSM states, timeout default, error width.
// Latency: n/a (package only).
// Backpressure: n/a.
// Optional feature macro: PHASE_CAL_AVG_EN (widens the phase-cal error accumulator by AVG_LOG2 bits).
package ising_config;

  localparam int num_bits          = 16;
  localparam int PHASE_CAL_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    PC_IDLE,
    PC_SET,
    PC_SETTLE,
    PC_MEAS,
    PC_EVAL,
    PC_DONE
  } phase_cal_state_t;

`ifdef PHASE_CAL_AVG_EN
  localparam bit PHASE_CAL_AVG_ON = 1'b1;
`else
  localparam bit PHASE_CAL_AVG_ON = 1'b0;
`endif

  // Accumulated-error width: one |diff| needs nb+1 bits, averaging adds log2(samples).
  function automatic int phase_cal_ew(input int nb, input int avg_log2);
    return nb + 1 + (PHASE_CAL_AVG_ON ? avg_log2 : 0);
  endfunction

endpackage

// File: rtl/abs_err_acc.sv
// Purpose: accumulates |sample - expv| (signed, sign-extended by one bit) into an unsigned register.
// Latency: 1 cycle from en to updated acc; clr has priority over en.
// Backpressure: none; every enabled cycle is consumed.
// Ports: clk, rst (sync active-low), clr, en, sample/expv (signed IW), acc (AW, AW >= IW+1).
module abs_err_acc #(
  parameter int IW = 16,
  parameter int AW = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [IW-1:0] sample,
  input  logic signed [IW-1:0] expv,
  output logic        [AW-1:0] acc
);

  logic signed [IW:0] diff;
  logic        [IW:0] mag;

  always_comb begin
    // One extra bit so the difference of two full-range signed words never wraps.
    diff = {sample[IW-1], sample} - {expv[IW-1], expv};
    mag  = diff[IW] ? -diff : diff;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(mag);
    end
  end

endmodule

// File: rtl/phase_cal_seq.sv
// Purpose: phase-calibration sequencer; sweeps phi_lo against MAC ADC then phi against NL ADC, keeps min-error words.
// Latency: per step 1 (SET) + settle_cycles + sample wait + 1 (EVAL); cal_done one cycle after final EVAL.
// Backpressure: none; samples are consumed only in MEAS, cal_trig ignored while busy, MEAS aborts after TIMEOUT idle cycles.
// Ports: clk, rst (sync active-low), cal_trig/busy/done/err, sweep config, DAC a/b/c words+valids,
//        ADC samples+strobes, mac_run/nl_run, phase words out, best errors out.
// Optional feature macro: PHASE_CAL_AVG_EN (2^AVG_LOG2 samples per step instead of one).
module phase_cal_seq
  import ising_config::*;
#(
  parameter  int AVG_LOG2 = 3,
  parameter  int TIMEOUT  = PHASE_CAL_TIMEOUT,
  localparam int EW       = phase_cal_ew(num_bits, AVG_LOG2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cal_trig,
  output logic                       cal_busy,
  output logic                       cal_done,
  output logic                       cal_err,
  input  logic [15:0]                num_steps,
  input  logic [15:0]                phi_step,
  input  logic [15:0]                settle_cycles,
  input  logic [15:0]                phi_lo_start,
  input  logic [15:0]                phi_start,
  input  logic [num_bits-1:0]        a_phase_cal,
  input  logic [num_bits-1:0]        b_phase_cal,
  input  logic [num_bits-1:0]        c_phase_cal,
  input  logic signed [num_bits-1:0] mac_phase_exp,
  input  logic signed [num_bits-1:0] nl_phase_exp,
  input  logic signed [num_bits-1:0] mac_val_in,
  input  logic signed [num_bits-1:0] nl_val_in,
  input  logic                       mac_val_valid,
  input  logic                       nl_val_valid,
  output logic                       mac_run,
  output logic                       nl_run,
  output logic [num_bits-1:0]        a_out,
  output logic [num_bits-1:0]        b_out,
  output logic [num_bits-1:0]        c_out,
  output logic                       a_valid,
  output logic                       b_valid,
  output logic                       c_valid,
  output logic [15:0]                phi_lo_val_out,
  output logic [15:0]                phi_val_out,
  output logic [EW-1:0]              best_mac_err,
  output logic [EW-1:0]              best_nl_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  phase_cal_state_t state;
  logic             stage;      // 0: phi_lo vs MAC, 1: phi vs NL
  logic [15:0]      cur_word;
  logic [15:0]      step_left;
  logic [15:0]      settle_cnt;
  logic [15:0]      best_lo;
  logic [15:0]      best_phi;
  logic [TW-1:0]    tmo_cnt;
`ifdef PHASE_CAL_AVG_EN
  logic [AVG_LOG2-1:0] samp_cnt;
`endif

  logic                       samp_vld;
  logic signed [num_bits-1:0] samp;
  logic signed [num_bits-1:0] expv;
  logic                       acc_clr;
  logic                       acc_en;
  logic [EW-1:0]              acc;
  logic                       last_samp;
  logic                       better;
  logic [15:0]                nxt_word;
  logic [15:0]                best_lo_nxt;
  logic [15:0]                best_phi_nxt;

  always_comb begin
    samp_vld     = stage ? nl_val_valid  : mac_val_valid;
    samp         = stage ? nl_val_in     : mac_val_in;
    expv         = stage ? nl_phase_exp  : mac_phase_exp;
    acc_clr      = (state == PC_SET);
    acc_en       = (state == PC_MEAS) && samp_vld;
    // Strict compare: a tie keeps the earlier phase word.
    better       = stage ? (acc < best_nl_err) : (acc < best_mac_err);
    nxt_word     = cur_word + phi_step;
    best_lo_nxt  = (!stage && better) ? cur_word : best_lo;
    best_phi_nxt = ( stage && better) ? cur_word : best_phi;
`ifdef PHASE_CAL_AVG_EN
    last_samp    = &samp_cnt;
`else
    last_samp    = 1'b1;
`endif
  end

  abs_err_acc #(.IW(num_bits), .AW(EW)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .sample (samp),
    .expv   (expv),
    .acc    (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= PC_IDLE;
      stage          <= 1'b0;
      cur_word       <= '0;
      step_left      <= '0;
      settle_cnt     <= '0;
      best_lo        <= '0;
      best_phi       <= '0;
      tmo_cnt        <= '0;
`ifdef PHASE_CAL_AVG_EN
      samp_cnt       <= '0;
`endif
      cal_busy       <= 1'b0;
      cal_done       <= 1'b0;
      cal_err        <= 1'b0;
      mac_run        <= 1'b0;
      nl_run         <= 1'b0;
      a_out          <= '0;
      b_out          <= '0;
      c_out          <= '0;
      a_valid        <= 1'b0;
      b_valid        <= 1'b0;
      c_valid        <= 1'b0;
      phi_lo_val_out <= '0;
      phi_val_out    <= '0;
      best_mac_err   <= '1;
      best_nl_err    <= '1;
    end else begin
      case (state)
        PC_IDLE: begin
          if (cal_trig) begin
            cur_word       <= phi_lo_start;
            step_left      <= num_steps;
            best_lo        <= phi_lo_start;
            best_phi       <= phi_start;
            best_mac_err   <= '1;
            best_nl_err    <= '1;
            stage          <= 1'b0;
            phi_lo_val_out <= phi_lo_start;
            phi_val_out    <= phi_start;
            a_valid        <= 1'b1;
            b_valid        <= 1'b1;
            c_valid        <= 1'b1;
            if (num_steps == 16'd0) begin
              cal_err  <= 1'b1;
              cal_done <= 1'b1;
              a_out    <= '0;
              b_out    <= '0;
              c_out    <= '0;
              mac_run  <= 1'b0;
              nl_run   <= 1'b0;
              state    <= PC_DONE;
            end else begin
              cal_err  <= 1'b0;
              cal_busy <= 1'b1;
              a_out    <= a_phase_cal;
              b_out    <= b_phase_cal;
              c_out    <= c_phase_cal;
              mac_run  <= 1'b1;
              nl_run   <= 1'b1;
              state    <= PC_SET;
            end
          end
        end

        PC_SET: begin
          tmo_cnt    <= '0;
          settle_cnt <= 16'd1;
`ifdef PHASE_CAL_AVG_EN
          samp_cnt   <= '0;
`endif
          state      <= (settle_cycles == 16'd0) ? PC_MEAS : PC_SETTLE;
        end

        PC_SETTLE: begin
          if (settle_cnt >= settle_cycles) state <= PC_MEAS;
          else                             settle_cnt <= settle_cnt + 16'd1;
        end

        PC_MEAS: begin
          if (samp_vld) begin
            // The idle-cycle timeout restarts on every accepted sample.
            tmo_cnt <= '0;
`ifdef PHASE_CAL_AVG_EN
            samp_cnt <= samp_cnt + 1'b1;
`endif
            if (last_samp) state <= PC_EVAL;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            cal_err        <= 1'b1;
            cal_busy       <= 1'b0;
            cal_done       <= 1'b1;
            a_out          <= '0;
            b_out          <= '0;
            c_out          <= '0;
            mac_run        <= 1'b0;
            nl_run         <= 1'b0;
            phi_lo_val_out <= best_lo;
            phi_val_out    <= best_phi;
            state          <= PC_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        PC_EVAL: begin
          if (better) begin
            if (stage) begin
              best_nl_err <= acc;
              best_phi    <= cur_word;
            end else begin
              best_mac_err <= acc;
              best_lo      <= cur_word;
            end
          end
          cur_word <= nxt_word;
          if (step_left > 16'd1) begin
            step_left <= step_left - 16'd1;
            if (stage) phi_val_out    <= nxt_word;
            else       phi_lo_val_out <= nxt_word;
            state <= PC_SET;
          end else if (!stage) begin
            // Stage 1 sweeps phi with phi_lo parked at the stage-0 winner.
            stage          <= 1'b1;
            step_left      <= num_steps;
            cur_word       <= phi_start;
            phi_lo_val_out <= best_lo_nxt;
            phi_val_out    <= phi_start;
            state          <= PC_SET;
          end else begin
            cal_busy       <= 1'b0;
            cal_done       <= 1'b1;
            a_out          <= '0;
            b_out          <= '0;
            c_out          <= '0;
            mac_run        <= 1'b0;
            nl_run         <= 1'b0;
            phi_lo_val_out <= best_lo;
            phi_val_out    <= best_phi_nxt;
            state          <= PC_DONE;
          end
        end

        PC_DONE: begin
          if (!cal_trig) begin
            cal_done <= 1'b0;
            state    <= PC_IDLE;
          end
        end

        default: state <= PC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_cal_seq.sv
// Purpose: randomized + directed bench for phase_cal_seq with a sweep-level reference model and result scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_phase_cal_seq;
  import ising_config::*;

  localparam int AVG = 3;
  localparam int EW  = phase_cal_ew(num_bits, AVG);
`ifdef PHASE_CAL_AVG_EN
  localparam int NS  = 1 << AVG;
`else
  localparam int NS  = 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cal_trig = 1'b0;
  logic                cal_busy, cal_done, cal_err;
  logic [15:0]         c_steps = 16'd1, c_step = '0, c_settle = '0, c_lo = '0, c_ph = '0;
  logic [15:0]         a_cal = '0, b_cal = '0, c_cal = '0;
  logic signed [15:0]  c_mexp = '0, c_nexp = '0;
  logic signed [15:0]  mac_val_in, nl_val_in;
  logic                mac_val_valid, nl_val_valid;
  logic                mac_run, nl_run;
  logic [15:0]         a_out, b_out, c_out;
  logic                a_valid, b_valid, c_valid;
  logic [15:0]         phi_lo_val_out, phi_val_out;
  logic [EW-1:0]       best_mac_err, best_nl_err;

  always #5 clk = ~clk;

  phase_cal_seq #(.AVG_LOG2(AVG), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .cal_trig(cal_trig), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_err(cal_err), .num_steps(c_steps), .phi_step(c_step), .settle_cycles(c_settle),
    .phi_lo_start(c_lo), .phi_start(c_ph), .a_phase_cal(a_cal), .b_phase_cal(b_cal),
    .c_phase_cal(c_cal), .mac_phase_exp(c_mexp), .nl_phase_exp(c_nexp),
    .mac_val_in(mac_val_in), .nl_val_in(nl_val_in), .mac_val_valid(mac_val_valid),
    .nl_val_valid(nl_val_valid), .mac_run(mac_run), .nl_run(nl_run), .a_out(a_out),
    .b_out(b_out), .c_out(c_out), .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid),
    .phi_lo_val_out(phi_lo_val_out), .phi_val_out(phi_val_out),
    .best_mac_err(best_mac_err), .best_nl_err(best_nl_err)
  );

  typedef struct {
    logic [15:0]   lo;
    logic [15:0]   ph;
    logic [EW-1:0] me;
    logic [EW-1:0] ne;
    logic          er;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Optical-path stand-in: each phase word maps to a fixed ADC reading.
  int          mac_map[int];
  int          nl_map[int];
  logic [15:0] salt = 16'h1234;
  bit          mute_mac = 1'b0;
  int          vld_div = 2;

  function automatic logic signed [15:0] mac_sample(input logic [15:0] w);
    if (mac_map.exists(int'(w))) return 16'(mac_map[int'(w)]);
    return 16'((w * 16'h9E37) ^ salt);
  endfunction

  function automatic logic signed [15:0] nl_sample(input logic [15:0] w);
    if (nl_map.exists(int'(w))) return 16'(nl_map[int'(w)]);
    return 16'((w * 16'h6B43) ^ ~salt);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Sweep model: walk both stages' phase words, keep the first strictly smallest error.
  function automatic exp_t model();
    exp_t        e;
    int          bm, bn, v;
    logic [15:0] w;
    e.lo = c_lo; e.ph = c_ph; e.er = 1'b0;
    bm = (1 << EW) - 1;
    bn = bm;
    if (c_steps == 16'd0 || mute_mac) begin
      e.er = 1'b1;
    end else begin
      for (int k = 0; k < int'(c_steps); k++) begin
        w = c_lo + 16'(k) * c_step;
        v = NS * iabs(int'(mac_sample(w)) - int'(c_mexp));
        if (v < bm) begin bm = v; e.lo = w; end
      end
      for (int k = 0; k < int'(c_steps); k++) begin
        w = c_ph + 16'(k) * c_step;
        v = NS * iabs(int'(nl_sample(w)) - int'(c_nexp));
        if (v < bn) begin bn = v; e.ph = w; end
      end
    end
    e.me = EW'(bm);
    e.ne = EW'(bn);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ADC drivers: present the reading for the currently driven phase word at random strobes.
  initial begin
    mac_val_valid = 1'b0; nl_val_valid = 1'b0; mac_val_in = '0; nl_val_in = '0;
    forever begin
      @(negedge clk);
      mac_val_valid = mac_run && !mute_mac && ($urandom_range(0, vld_div - 1) == 0);
      mac_val_in    = mac_sample(phi_lo_val_out);
      nl_val_valid  = nl_run && ($urandom_range(0, vld_div - 1) == 0);
      nl_val_in     = nl_sample(phi_val_out);
    end
  end

  // Result monitor: each cal_done rising edge retires one expected result.
  initial begin
    exp_t e;
    logic done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (cal_done && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_phi_lo", 64'(phi_lo_val_out), 64'(e.lo));
          chk("done_phi",    64'(phi_val_out),    64'(e.ph));
          chk("done_mac_err", 64'(best_mac_err),  64'(e.me));
          chk("done_nl_err",  64'(best_nl_err),   64'(e.ne));
          chk("done_cal_err", 64'(cal_err),       64'(e.er));
          chk("done_dac", 64'({a_out, b_out, c_out, a_valid, b_valid, c_valid, mac_run, nl_run, cal_busy}),
              64'({48'd0, 3'b111, 3'b000}));
        end
      end
      done_q = cal_done;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, 64'({cal_busy, cal_done, cal_err, a_valid, b_valid, c_valid, mac_run, nl_run}), 64'd0);
    chk({tag, "_dac"},   64'({a_out, b_out, c_out}), 64'd0);
    chk({tag, "_phase"}, 64'({phi_lo_val_out, phi_val_out}), 64'd0);
    chk({tag, "_errs"},  64'({best_mac_err, best_nl_err}), {{(64 - 2 * EW){1'b0}}, {(2 * EW){1'b1}}});
  endtask

  task automatic run_cal(output int cyc);
    sb.push_back(model());
    @(negedge clk);
    cal_trig = 1'b1;
    cyc = 0;
    @(negedge clk);
    cyc++;
    if (c_steps != 16'd0)
      chk("set_outputs", 64'({cal_busy, a_out, b_out, c_out, a_valid, mac_run, nl_run}),
          64'({1'b1, a_cal, b_cal, c_cal, 1'b1, 1'b1, 1'b1}));
    while (!cal_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (!cal_done) begin
      chk("done_wait", 64'(cyc), 64'd0);
      sb.delete();
    end
    cal_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_cfg();
    mac_map.delete(); nl_map.delete();
    c_steps  = 16'($urandom_range(1, 6));
    c_step   = 16'($urandom);
    c_settle = 16'($urandom_range(0, 3));
    c_lo     = 16'($urandom);
    c_ph     = 16'($urandom);
    c_mexp   = 16'($urandom);
    c_nexp   = 16'($urandom);
    a_cal    = 16'($urandom); b_cal = 16'($urandom); c_cal = 16'($urandom);
    salt     = 16'($urandom);
    vld_div  = $urandom_range(1, 3);
    mute_mac = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // MAC error minimal at step 5 of 16.
    rand_cfg();
    c_lo = 16'h0000; c_ph = 16'h0000; c_step = 16'h1000; c_steps = 16'd16; c_settle = 16'd4;
    c_mexp = 16'sd0;
    for (int k = 0; k < 16; k++) mac_map[k * 32'h1000] = 50 + 10 * iabs(k - 5);
    run_cal(cyc);
    chk("t1_lo", 64'(phi_lo_val_out), 64'h5000);

    // NL minimum past the 16-bit wrap: F000 + 2 steps = 1000.
    rand_cfg();
    c_ph = 16'hF000; c_step = 16'h1000; c_steps = 16'd4; c_nexp = -16'sd200;
    nl_map[32'hF000] = -160; nl_map[32'h0000] = -180; nl_map[32'h1000] = -195; nl_map[32'h2000] = -170;
    run_cal(cyc);
    chk("t2_phi", 64'(phi_val_out), 64'h1000);

    // Two equal minima (error 7 each): earlier word wins.
    rand_cfg();
    c_lo = 16'h0100; c_step = 16'h0040; c_steps = 16'd4; c_mexp = 16'sd1000;
    mac_map[32'h0100] = 1100; mac_map[32'h0140] = 1007; mac_map[32'h0180] = 993; mac_map[32'h01C0] = 1100;
    run_cal(cyc);
    chk("t3_tie", 64'(phi_lo_val_out), 64'h0140);

    // No MAC samples: timeout, start words kept.
    rand_cfg();
    mute_mac = 1'b1;
    run_cal(cyc);
    chk("t4_tmo_len", 64'(cyc >= 1023), 64'd1);
    mute_mac = 1'b0;

    // num_steps == 0: DONE next cycle, held while cal_trig stays high.
    rand_cfg();
    c_steps = 16'd0;
    sb.push_back(model());
    @(negedge clk); cal_trig = 1'b1;
    @(negedge clk);
    chk("t5_done_now", 64'({cal_done, cal_busy, cal_err}), 64'b101);
    repeat (3) @(negedge clk);
    chk("t5_hold", 64'(cal_done), 64'd1);
    cal_trig = 1'b0;
    @(negedge clk);
    chk("t5_idle", 64'(cal_done), 64'd0);

    // Reset during stage-1 measurement.
    rand_cfg();
    c_steps = 16'd4; c_step = 16'h0800; c_settle = 16'd2; vld_div = 8;
    @(negedge clk); cal_trig = 1'b1;
    cyc = 0;
    while (phi_val_out != c_ph + c_step && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("t6_reach_stage1", 64'(phi_val_out), 64'(c_ph + c_step));
    cal_trig = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("t6_reset");
    rst = 1'b1;
    @(negedge clk);
    rand_cfg();
    run_cal(cyc);

    // Random sweeps.
    for (int r = 0; r < 12; r++) begin
      rand_cfg();
      run_cal(cyc);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
